// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared definitions for the ring-router output-port controller: port
// indices, default message width, queue depth and round-robin helpers.
package plab4_net_router_output_ctrl_pkg;

  // Number of input controllers competing for one output port
  localparam int unsigned NUM_PORTS   = 32'd3;

  // Default network message width (header + payload)
  localparam int unsigned MSG_NBITS   = 32'd32;

  // Output queue depth; the pointer/count logic assumes exactly two entries
  localparam int unsigned QUEUE_DEPTH = 32'd2;

  // Port indices, also used as priority-pointer and winner encodings
  localparam logic [1:0] PORT_0 = 2'd0;
  localparam logic [1:0] PORT_1 = 2'd1;
  localparam logic [1:0] PORT_2 = 2'd2;

  // The 2-bit pointer has one illegal code (3); fold it back onto port 0
  function automatic logic [1:0] sanitize_ptr(input logic [1:0] ptr);
    logic [1:0] res;
    if (ptr == 2'd3) begin
      res = PORT_0;
    end else begin
      res = ptr;
    end
    return res;
  endfunction

  // Priority pointer after a win: the port just past the winner, mod 3
  function automatic logic [1:0] next_ptr(input logic [1:0] winner);
    logic [1:0] res;
    case (winner)
      PORT_0:  res = PORT_1;
      PORT_1:  res = PORT_2;
      PORT_2:  res = PORT_0;
      default: res = PORT_0;
    endcase
    return res;
  endfunction

  // One-hot grant vector for a port index
  function automatic logic [2:0] port_onehot(input logic [1:0] idx);
    logic [2:0] res;
    case (idx)
      PORT_0:  res = 3'b001;
      PORT_1:  res = 3'b010;
      PORT_2:  res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_arb.sv
// Three-way round-robin arbiter. Purely combinational: searches the request
// vector starting at the priority pointer and wrapping mod 3, and reports the
// one-hot grant plus the winner index. Grants are suppressed when disabled.
module plab4_net_router_output_ctrl_arb
  import plab4_net_router_output_ctrl_pkg::*;
(
  input  logic [2:0] i_reqs,
  input  logic [1:0] i_ptr,
  input  logic       i_en,
  output logic [2:0] o_grants,
  output logic [1:0] o_winner
);

  logic [1:0] w_ptr;
  logic       w_found;
  logic [1:0] w_winner;

  // Pick the first requester in the order ptr, ptr+1, ptr+2 (mod 3)
  always_comb begin
    w_ptr    = sanitize_ptr(i_ptr);
    w_found  = 1'b0;
    w_winner = PORT_0;
    case (w_ptr)
      PORT_1: begin
        if (i_reqs[1]) begin
          w_found = 1'b1; w_winner = PORT_1;
        end else if (i_reqs[2]) begin
          w_found = 1'b1; w_winner = PORT_2;
        end else if (i_reqs[0]) begin
          w_found = 1'b1; w_winner = PORT_0;
        end else begin
          w_found = 1'b0; w_winner = PORT_0;
        end
      end
      PORT_2: begin
        if (i_reqs[2]) begin
          w_found = 1'b1; w_winner = PORT_2;
        end else if (i_reqs[0]) begin
          w_found = 1'b1; w_winner = PORT_0;
        end else if (i_reqs[1]) begin
          w_found = 1'b1; w_winner = PORT_1;
        end else begin
          w_found = 1'b0; w_winner = PORT_0;
        end
      end
      default: begin
        // PORT_0, and the folded illegal code
        if (i_reqs[0]) begin
          w_found = 1'b1; w_winner = PORT_0;
        end else if (i_reqs[1]) begin
          w_found = 1'b1; w_winner = PORT_1;
        end else if (i_reqs[2]) begin
          w_found = 1'b1; w_winner = PORT_2;
        end else begin
          w_found = 1'b0; w_winner = PORT_0;
        end
      end
    endcase
  end

  // Qualify the winner with the enable; no grant when nothing was found
  always_comb begin
    if (i_en && w_found) begin
      o_grants = port_onehot(w_winner);
    end else begin
      o_grants = 3'b000;
    end
    o_winner = w_winner;
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Per-output-port controller of the ring router. Arbitrates round-robin
// among the three input controllers, muxes the winning head message into a
// two-entry output queue, and drives the outgoing val/rdy channel from the
// queue head. Enqueued data becomes visible one cycle after the grant.
module plab4_net_router_output_ctrl
  import plab4_net_router_output_ctrl_pkg::*;
#(
  parameter int unsigned p_msg_nbits   = MSG_NBITS,
  parameter int unsigned p_num_entries = QUEUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             i_reqs,
  output logic [2:0]             o_grants,
  input  logic [p_msg_nbits-1:0] i_in_msg0,
  input  logic [p_msg_nbits-1:0] i_in_msg1,
  input  logic [p_msg_nbits-1:0] i_in_msg2,
  output logic                   o_out_val,
  input  logic                   i_out_rdy,
  output logic [p_msg_nbits-1:0] o_out_msg
);

  // Occupancy at which the queue refuses further grants
  localparam logic [1:0] FULL_COUNT = 2'(p_num_entries);

  logic [1:0]             r_ptr;
  logic [1:0]             r_count;
  logic                   r_enq_ptr;
  logic                   r_deq_ptr;
  logic [p_msg_nbits-1:0] r_data [0:1];

  logic                   w_arb_en;
  logic [2:0]             w_grants;
  logic [1:0]             w_winner;
  logic                   w_enq;
  logic                   w_deq;
  logic [p_msg_nbits-1:0] w_enq_msg;

  // Grants only while there is room and the block is out of reset, so an
  // input controller never sees a grant during reset or into a full queue.
  // out_rdy deliberately plays no part: a full queue is never bypassed.
  assign w_arb_en = (r_count < FULL_COUNT) && rst_n;

  plab4_net_router_output_ctrl_arb u_arb (
    .i_reqs   (i_reqs),
    .i_ptr    (r_ptr),
    .i_en     (w_arb_en),
    .o_grants (w_grants),
    .o_winner (w_winner)
  );

  assign o_grants  = w_grants;
  assign w_enq     = |w_grants;
  assign o_out_val = (r_count != 2'd0);
  assign w_deq     = o_out_val && i_out_rdy;
  assign o_out_msg = r_data[r_deq_ptr];

  // Select the winning input's head message for enqueue
  always_comb begin
    case (w_winner)
      PORT_0:  w_enq_msg = i_in_msg0;
      PORT_1:  w_enq_msg = i_in_msg1;
      PORT_2:  w_enq_msg = i_in_msg2;
      default: w_enq_msg = i_in_msg0;
    endcase
  end

  // Priority pointer moves past the winner on a transfer, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_0;
    end else if (w_enq) begin
      r_ptr <= next_ptr(w_winner);
    end else begin
      r_ptr <= sanitize_ptr(r_ptr);
    end
  end

  // Occupancy: +1 enq-only, -1 deq-only, unchanged on both or neither
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      case ({w_enq, w_deq})
        2'b10: begin
          if (r_count < FULL_COUNT) begin
            r_count <= r_count + 2'd1;
          end else begin
            r_count <= r_count;
          end
        end
        2'b01: begin
          if (r_count != 2'd0) begin
            r_count <= r_count - 2'd1;
          end else begin
            r_count <= r_count;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  // Tail pointer toggles on each enqueue (two entries, wraps 1->0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enq_ptr <= 1'b0;
    end else if (w_enq) begin
      r_enq_ptr <= ~r_enq_ptr;
    end else begin
      r_enq_ptr <= r_enq_ptr;
    end
  end

  // Head pointer toggles on each dequeue (two entries, wraps 1->0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deq_ptr <= 1'b0;
    end else if (w_deq) begin
      r_deq_ptr <= ~r_deq_ptr;
    end else begin
      r_deq_ptr <= r_deq_ptr;
    end
  end

  // Queue storage; cleared on reset so dropped messages cannot resurface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= {p_msg_nbits{1'b0}};
      r_data[1] <= {p_msg_nbits{1'b0}};
    end else if (w_enq) begin
      r_data[r_enq_ptr] <= w_enq_msg;
    end else begin
      r_data[0] <= r_data[0];
      r_data[1] <= r_data[1];
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Directed, table-driven bench for the router output-port controller.
module tb_plab4_net_router_output_ctrl;

  localparam logic [31:0] M0 = 32'h1111_0000;
  localparam logic [31:0] M1 = 32'h2222_0001;
  localparam logic [31:0] M2 = 32'h3333_0002;
  localparam logic [31:0] MA = 32'h0000_00A5;
  localparam logic [31:0] MB = 32'h0000_00B6;

  logic        clk;
  logic        rst_n;
  logic [2:0]  reqs;
  logic [2:0]  grants;
  logic [31:0] in_msg0, in_msg1, in_msg2;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic [2:0]  reqs;
    logic        rdy;
    logic [31:0] m1;
    logic [2:0]  exp_g;
    logic        exp_v;
    logic [31:0] exp_m;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  plab4_net_router_output_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_reqs    (reqs),
    .o_grants  (grants),
    .i_in_msg0 (in_msg0),
    .i_in_msg1 (in_msg1),
    .i_in_msg2 (in_msg2),
    .o_out_val (out_val),
    .i_out_rdy (out_rdy),
    .o_out_msg (out_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    reqs    = 3'b111;
    out_rdy = 1'b1;
    in_msg0 = M0;
    in_msg1 = M1;
    in_msg2 = M2;

    //          rst   reqs    rdy   m1   exp_g   exp_v exp_m
    // reset held with all requesting, then round-robin fairness
    vecs[0]  = '{1'b0, 3'b111, 1'b1, M1, 3'b000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 3'b111, 1'b1, M1, 3'b001, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'b111, 1'b1, M1, 3'b010, 1'b1, M0};
    vecs[3]  = '{1'b1, 3'b111, 1'b1, M1, 3'b100, 1'b1, M1};
    vecs[4]  = '{1'b1, 3'b111, 1'b1, M1, 3'b001, 1'b1, M2};
    vecs[5]  = '{1'b1, 3'b000, 1'b1, M1, 3'b000, 1'b1, M0};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, M1, 3'b000, 1'b0, 32'h0};
    // backpressure: two grants fill the queue, then none until a slot frees
    vecs[7]  = '{1'b1, 3'b010, 1'b0, MA, 3'b010, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 1'b0, MA, 3'b010, 1'b1, MA};
    vecs[9]  = '{1'b1, 3'b010, 1'b0, MA, 3'b000, 1'b1, MA};
    vecs[10] = '{1'b1, 3'b010, 1'b1, MA, 3'b000, 1'b1, MA};
    vecs[11] = '{1'b1, 3'b010, 1'b1, MB, 3'b010, 1'b1, MA};
    vecs[12] = '{1'b1, 3'b000, 1'b1, MB, 3'b000, 1'b1, MB};
    // ptr=2, reqs=011 -> port 0 wins, ptr becomes 1
    vecs[13] = '{1'b1, 3'b011, 1'b1, M1, 3'b001, 1'b0, 32'h0};
    // enq+deq at count 1 with a single requester
    vecs[14] = '{1'b1, 3'b100, 1'b1, M1, 3'b100, 1'b1, M0};
    vecs[15] = '{1'b1, 3'b100, 1'b1, M1, 3'b100, 1'b1, M2};
    vecs[16] = '{1'b1, 3'b000, 1'b1, M1, 3'b000, 1'b1, M2};
    // ptr back at 0 after port 2 won; fill to count 2
    vecs[17] = '{1'b1, 3'b111, 1'b0, M1, 3'b001, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 3'b111, 1'b0, M1, 3'b010, 1'b1, M0};
    vecs[19] = '{1'b1, 3'b111, 1'b0, M1, 3'b000, 1'b1, M0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      reqs    = vecs[i].reqs;
      out_rdy = vecs[i].rdy;
      in_msg1 = vecs[i].m1;
      #2;
      check($sformatf("v%0d grants", i), {29'd0, grants}, {29'd0, vecs[i].exp_g});
      check($sformatf("v%0d out_val", i), {31'd0, out_val}, {31'd0, vecs[i].exp_v});
      if (vecs[i].exp_v) begin
        check($sformatf("v%0d out_msg", i), out_msg, vecs[i].exp_m);
      end
    end

    // Asynchronous reset while full: out_val drops before any clock edge
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst out_val", {31'd0, out_val}, 32'd0);
    check("async_rst grants", {29'd0, grants}, 32'd0);

    @(negedge clk);
    rst_n   = 1'b1;
    reqs    = 3'b000;
    out_rdy = 1'b1;
    in_msg1 = M1;
    #2;
    check("post_rst out_val", {31'd0, out_val}, 32'd0);

    @(negedge clk);
    reqs = 3'b100;
    #2;
    check("post_rst grants", {29'd0, grants}, 32'd4);
    check("post_rst empty", {31'd0, out_val}, 32'd0);

    @(negedge clk);
    reqs = 3'b000;
    #2;
    check("post_rst val", {31'd0, out_val}, 32'd1);
    check("post_rst msg", out_msg, M2);

    @(negedge clk);
    #2;
    check("post_rst drained", {31'd0, out_val}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
